mult_booth4_pipe: RTL and testbench

//   Parametrised, pipelined radix-4 Booth multiplier with a valid/ready stream interface.
//   It replaces fixed-width registered multiplier wrappers in the multiplier sweep flow.

---
 rtl/mult_booth4_pipe.sv | 248 ++++++++++++++++++++++++
 tb/tb_mult_booth4_pipe.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth4_pipe.sv
// -----------------------------------------------------------------------------
// mult_booth4_pipe
//   Pipelined radix-4 Booth multiplier with a valid/ready stream interface.
//   Each transaction selects signed or unsigned operands and carries a sideband
//   tag that is returned unchanged with its product. With out_ready held high
//   the pipeline delivers one product per cycle, and empty slots are always
//   filled when their upstream neighbour holds data (bubbles collapse).
//
//   Ports
//     clk, rst_n            rising-edge clock, asynchronous active-low reset
//     in_valid / in_ready   upstream handshake (in_ready is combinational)
//     in_signed             1: both operands two's complement, 0: both unsigned
//     multiplicand (A)      WIDTH-bit operand
//     multiplier   (B)      WIDTH-bit operand
//     in_tag               TAG_W-bit sideband
//     out_valid / out_ready downstream handshake
//     product               2*WIDTH-bit exact product A*B
//     out_tag               tag of the pair that produced product
//
//   Slot layout (s0 .. s(STAGES-1), the last slot drives the outputs)
//     STAGES == 1 : s0 = product, all arithmetic before the register
//     STAGES == 2 : s0 = extended operands, s1 = product
//     STAGES >= 3 : s0 = extended operands, s1 = carry-save sum/carry,
//                   s2 = product after the prefix adder, s3.. = product copies
// -----------------------------------------------------------------------------
module mult_booth4_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int XW = WIDTH + 2;        // extended operand width
    localparam int PW = 2 * WIDTH;        // product width
    localparam int ND = XW / 2;           // number of Booth digits
    localparam int LV = $clog2(PW);       // prefix-tree levels
    // Index of the first slot that holds a finished product, and how many do.
    localparam int PS = (STAGES >= 3) ? 2 : (STAGES - 1);
    localparam int NP = STAGES - PS;
    localparam logic [PW-1:0] ONE_PW = {{(PW-1){1'b0}}, 1'b1};

    // Two extra bits make every operand representable as a signed XW-bit value,
    // so unsigned operands need no special Booth handling.
    function automatic logic [XW-1:0] ext_op(input logic [WIDTH-1:0] x, input logic sgn);
        ext_op = {{2{sgn & x[WIDTH-1]}}, x};
    endfunction

    // One partial product (unshifted) for Booth digit encoded by {b[2i+1], b[2i], b[2i-1]}.
    function automatic logic [PW-1:0] booth_pp(input logic [XW-1:0] a, input logic [2:0] dig);
        logic [PW-1:0] a_w;
        logic [PW-1:0] a_2;
        a_w = {{(PW-XW){a[XW-1]}}, a};
        a_2 = {a_w[PW-2:0], 1'b0};
        case (dig)
            3'b001, 3'b010: booth_pp = a_w;
            3'b011:         booth_pp = a_2;
            3'b100:         booth_pp = ~a_2 + ONE_PW;
            3'b101, 3'b110: booth_pp = ~a_w + ONE_PW;
            default:        booth_pp = {PW{1'b0}};
        endcase
    endfunction

    // Booth partial products folded by a chain of 3:2 compressors into {sum, carry}.
    // Everything is modulo 2^PW, which is exact for the low PW product bits.
    function automatic logic [2*PW-1:0] booth_csa(input logic [XW-1:0] a, input logic [XW-1:0] b);
        logic [XW:0]   bz;
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] pp;
        logic [PW-1:0] t;
        logic [PW-1:0] m;
        bz = {b, 1'b0};
        s  = {PW{1'b0}};
        c  = {PW{1'b0}};
        for (int i = 0; i < ND; i++) begin
            pp = booth_pp(a, bz[2*i +: 3]) << (2 * i);
            t  = s ^ c ^ pp;
            m  = (s & c) | (s & pp) | (c & pp);
            c  = {m[PW-2:0], 1'b0};
            s  = t;
        end
        booth_csa = {s, c};
    endfunction

    // Sklansky parallel-prefix adder (carry-in 0). At level l every bit with
    // index bit l set absorbs the group ending just below its 2^l block; that
    // source bit has index bit l clear, so in-place update is safe.
    function automatic logic [PW-1:0] sklansky_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
        logic [PW-1:0] g;
        logic [PW-1:0] p;
        logic [PW-1:0] p0;
        logic [PW-1:0] sum;
        int            j;
        g  = x & y;
        p  = x ^ y;
        p0 = p;
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < PW; i++) begin
                if (((i >> l) & 1) == 1) begin
                    j    = ((i >> l) << l) - 1;
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        sum[0] = p0[0];
        for (int i = 1; i < PW; i++) begin
            sum[i] = p0[i] ^ g[i-1];
        end
        sklansky_add = sum;
    endfunction

    // Complete multiply of two extended operands.
    function automatic logic [PW-1:0] booth_mul(input logic [XW-1:0] a, input logic [XW-1:0] b);
        logic [2*PW-1:0] sc;
        sc        = booth_csa(a, b);
        booth_mul = sklansky_add(sc[2*PW-1:PW], sc[PW-1:0]);
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] free_s;   // slot can take new data this cycle
    logic [STAGES-1:0] feed_s;   // upstream of slot holds valid data
    logic [STAGES-1:0] ld_s;     // slot captures new data this cycle
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [PW-1:0]     prod_in_s;
    logic [PW-1:0]     prod_q [NP];

    // Readiness ripples back from out_ready: a slot is free if empty or if its
    // occupant moves on this cycle.
    always_comb begin
        logic nxt;
        nxt    = out_ready;
        free_s = {STAGES{1'b0}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            free_s[k] = ~v_q[k] | nxt;
            nxt       = free_s[k];
        end
    end

    // Upstream-valid per slot, load enables and next valid bits.
    always_comb begin
        feed_s    = {STAGES{1'b0}};
        feed_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            feed_s[k] = v_q[k-1];
        end
        ld_s = free_s & feed_s;
        v_d  = (free_s & feed_s) | (~free_s & v_q);
    end

    assign in_ready = free_s[0];

    // Valid bits and tags move together through every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                tag_q[k] <= {TAG_W{1'b0}};
            end
        end else begin
            v_q <= v_d;
            if (ld_s[0]) begin
                tag_q[0] <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld_s[k]) begin
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end
    end

    generate
        if (STAGES >= 2) begin : g_ops
            logic [XW-1:0] opa_q;
            logic [XW-1:0] opb_q;

            // s0: the extension already encodes the per-transaction mode.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_q <= {XW{1'b0}};
                    opb_q <= {XW{1'b0}};
                end else if (ld_s[0]) begin
                    opa_q <= ext_op(multiplicand, in_signed);
                    opb_q <= ext_op(multiplier, in_signed);
                end
            end

            if (STAGES >= 3) begin : g_csa
                logic [PW-1:0] sum_q;
                logic [PW-1:0] carry_q;

                // s1: partial products generated and reduced to two vectors.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sum_q   <= {PW{1'b0}};
                        carry_q <= {PW{1'b0}};
                    end else if (ld_s[1]) begin
                        {sum_q, carry_q} <= booth_csa(opa_q, opb_q);
                    end
                end

                assign prod_in_s = sklansky_add(sum_q, carry_q);
            end else begin : g_direct
                assign prod_in_s = booth_mul(opa_q, opb_q);
            end
        end else begin : g_comb
            assign prod_in_s = booth_mul(ext_op(multiplicand, in_signed),
                                         ext_op(multiplier, in_signed));
        end
    endgenerate

    // Product slots: the first captures the finished sum, the rest shift it on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                prod_q[p] <= {PW{1'b0}};
            end
        end else begin
            if (ld_s[PS]) begin
                prod_q[0] <= prod_in_s;
            end
            for (int p = 1; p < NP; p++) begin
                if (ld_s[PS+p]) begin
                    prod_q[p] <= prod_q[p-1];
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign product   = prod_q[NP-1];
    assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_mult_booth4_pipe.sv
// Testbench for mult_booth4_pipe: main instance 16/3/4 plus sweep instances
// 8/1 and 32/4. Expected products come from plain 64-bit arithmetic.
module tb_mult_booth4_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [15:0] a, b;
    logic [3:0]  in_tag, out_tag;
    logic [31:0] product;

    logic        x8_iv, x8_ir, x8_sg, x8_ov, x8_or;
    logic [7:0]  x8_a, x8_b;
    logic [2:0]  x8_tag, x8_otag;
    logic [15:0] x8_prod;

    logic        x32_iv, x32_ir, x32_sg, x32_ov, x32_or;
    logic [31:0] x32_a, x32_b;
    logic [3:0]  x32_tag, x32_otag;
    logic [63:0] x32_prod;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_acc_cyc, first_ov_cyc, last_acc_cyc;
    logic last_acc, last_del, s_in_ready, s_out_valid;
    logic [31:0] s_prod;
    logic [3:0]  s_tag;
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];

    mult_booth4_pipe #(.WIDTH(16), .STAGES(3), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .multiplicand(a), .multiplier(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .out_tag(out_tag));

    mult_booth4_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(x8_iv), .in_ready(x8_ir),
        .in_signed(x8_sg), .multiplicand(x8_a), .multiplier(x8_b), .in_tag(x8_tag),
        .out_valid(x8_ov), .out_ready(x8_or), .product(x8_prod), .out_tag(x8_otag));

    mult_booth4_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(x32_iv), .in_ready(x32_ir),
        .in_signed(x32_sg), .multiplicand(x32_a), .multiplier(x32_b), .in_tag(x32_tag),
        .out_valid(x32_ov), .out_ready(x32_or), .product(x32_prod), .out_tag(x32_otag));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend each operand to 64 bits per mode, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] av, input logic [63:0] bv,
                                            input logic sg, input int w);
        logic [63:0] hi, ax, bx, pr;
        hi = ~((64'd1 << w) - 64'd1);
        ax = (sg && av[w-1]) ? (av | hi) : av;
        bx = (sg && bv[w-1]) ? (bv | hi) : bv;
        pr = ax * bx;
        if (w < 32) pr = pr & ((64'd1 << (2 * w)) - 64'd1);
        return pr;
    endfunction

    // Random value biased toward the interesting corners of a w-bit operand.
    function automatic logic [31:0] pick(input int w);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = 32'd1 << (w - 1);
            1: r = 32'hFFFF_FFFF;
            2: r = (32'd1 << (w - 1)) - 32'd1;
            3: r = 32'd0;
            default: r = r;
        endcase
        return r;
    endfunction

    // One clock: sample at negedge, log handshakes into the scoreboard queues.
    task automatic tick();
        logic [63:0] r;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_prod      = product;
        s_tag       = out_tag;
        last_acc    = in_valid && in_ready;
        last_del    = out_valid && out_ready;
        if (last_acc) begin
            r = ref_mul({48'd0, a}, {48'd0, b}, in_signed, 16);
            exp_q.push_back({in_tag, r[31:0]});
            last_acc_cyc = cyc;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (s_out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (last_del) got_q.push_back({out_tag, product});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive_rand(input logic [3:0] tg);
        logic [31:0] r;
        r = $urandom;
        a = r[15:0];
        b = r[31:16];
        in_signed = 1'($urandom_range(0, 1));
        in_tag = tg;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sg, input logic [3:0] tg);
        a = av; b = bv; in_signed = sg; in_tag = tg; in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: tag %0d never accepted", tg);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick();
        tick();
        tick();
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        first_acc_cyc = -1;
        first_ov_cyc = -1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_chk++; if (product !== 32'd0) begin n_fail++; $display("FAIL rst_product: got %h want 0", product); end
        n_chk++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL rst_out_tag: got %h want 0", out_tag); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_signed_corners();
        logic [35:0] want [3];
        want[0] = {4'd1, 32'h4000_0000};
        want[1] = {4'd2, 32'hFFFF_FFFF};
        want[2] = {4'd3, 32'hC000_8000};
        clear_sb();
        out_ready = 1'b1;
        send(16'h8000, 16'h8000, 1'b1, 4'd1);
        send(16'hFFFF, 16'h0001, 1'b1, 4'd2);
        send(16'h7FFF, 16'h8000, 1'b1, 4'd3);
        drain();
        n_chk++; if (got_q.size() != 3) begin n_fail++; $display("FAIL sc_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL sc_result%0d: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_unsigned_corners();
        logic [35:0] want [3];
        int c2;
        want[0] = {4'd4, 32'hFFFE_0001};
        want[1] = {4'd5, 32'h0001_0000};
        want[2] = {4'd6, 32'h0000_0001};
        clear_sb();
        out_ready = 1'b1;
        send(16'hFFFF, 16'hFFFF, 1'b0, 4'd4);
        send(16'h8000, 16'h0002, 1'b0, 4'd5);
        c2 = last_acc_cyc;
        send(16'hFFFF, 16'hFFFF, 1'b1, 4'd6);
        n_chk++; if (last_acc_cyc - c2 != 1) begin n_fail++; $display("FAIL uc_next_cycle: gap %0d want 1", last_acc_cyc - c2); end
        drain();
        n_chk++; if (got_q.size() != 3) begin n_fail++; $display("FAIL uc_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL uc_result%0d: got %h want %h", i, got_q[i], want[i]); end
        end
    endtask

    task automatic test_throughput();
        int lows = 0;
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive_rand(4'(i));
            tick();
            if (!s_in_ready) lows++;
        end
        drain();
        n_chk++; if (lows != 0) begin n_fail++; $display("FAIL tp_in_ready_low: got %0d cycles want 0", lows); end
        n_chk++; if (first_ov_cyc - first_acc_cyc != 3) begin n_fail++; $display("FAIL tp_latency: got %0d want 3", first_ov_cyc - first_acc_cyc); end
        n_chk++; if (got_q.size() != 100 || exp_q.size() != 100) begin n_fail++; $display("FAIL tp_count: got %0d/%0d want 100", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 100 && i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tp_result%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p0;
        logic [3:0]  t0;
        int acc_cnt = 0;
        int tg = 0;
        clear_sb();
        out_ready = 1'b0;
        drive_rand(4'(tg)); tg++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_acc) begin acc_cnt++; drive_rand(4'(tg)); tg++; end
            if (i == 3) begin
                p0 = s_prod; t0 = s_tag;
                n_chk++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", s_out_valid); end
            end
            if (i > 3) begin
                n_chk++;
                if ({s_tag, s_prod} !== {t0, p0}) begin n_fail++; $display("FAIL bp_stable: got %h want %h", {s_tag, s_prod}, {t0, p0}); end
            end
        end
        n_chk++; if (acc_cnt != 3) begin n_fail++; $display("FAIL bp_accepts: got %0d want 3", acc_cnt); end
        n_chk++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", s_in_ready); end
        out_ready = 1'b1;
        tick();
        n_chk++; if (!(last_acc && last_del)) begin n_fail++; $display("FAIL bp_fill_drain: got acc=%b del=%b want 1/1", last_acc, last_del); end
        for (int i = 0; i < 5; i++) begin
            if (last_acc) begin drive_rand(4'(tg)); tg++; end
            tick();
        end
        drain();
        n_chk++; if (got_q.size() != 9 || exp_q.size() != 9) begin n_fail++; $display("FAIL bp_count: got %0d/%0d want 9", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_result%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_bubble();
        int lows = 0;
        int c1;
        clear_sb();
        out_ready = 1'b0;
        drive_rand(4'd10);
        tick();
        n_chk++; if (!last_acc) begin n_fail++; $display("FAIL bub_first: got acc=%b want 1", last_acc); end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!s_in_ready) lows++;
        end
        drive_rand(4'd11);
        tick();
        c1 = last_acc_cyc;
        if (!s_in_ready) lows++;
        drive_rand(4'd12);
        tick();
        if (!s_in_ready) lows++;
        n_chk++; if (lows != 0) begin n_fail++; $display("FAIL bub_in_ready_low: got %0d cycles want 0", lows); end
        n_chk++; if (exp_q.size() != 3 || last_acc_cyc - c1 != 1) begin n_fail++; $display("FAIL bub_consecutive: got %0d accepts gap %0d want 3 gap 1", exp_q.size(), last_acc_cyc - c1); end
        in_valid = 1'b0;
        tick();
        n_chk++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL bub_full: got in_ready %b want 0", s_in_ready); end
        drain();
        n_chk++; if (got_q.size() != 3) begin n_fail++; $display("FAIL bub_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bub_result%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int ov_seen = 0;
        clear_sb();
        out_ready = 1'b0;
        send(16'h1234, 16'h0055, 1'b0, 4'd7);
        send(16'hF00D, 16'h0AAA, 1'b1, 4'd8);
        in_valid = 1'b0;
        tick();
        tick();
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_inflight: got out_valid %b want 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        n_chk++; if (product !== 32'd0) begin n_fail++; $display("FAIL rm_product: got %h want 0", product); end
        clear_sb();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_out_valid) ov_seen++;
        end
        n_chk++; if (ov_seen != 0) begin n_fail++; $display("FAIL rm_stale: got %0d valid cycles want 0", ov_seen); end
        send(16'd7, 16'hFFFD, 1'b1, 4'd9);
        drain();
        n_chk++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rm_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_chk++;
            if (got_q[0] !== {4'd9, 32'hFFFF_FFEB}) begin n_fail++; $display("FAIL rm_result: got %h want %h", got_q[0], {4'd9, 32'hFFFF_FFEB}); end
        end
    endtask

    task automatic new8();
        logic [31:0] t;
        t = pick(8); x8_a = t[7:0];
        t = pick(8); x8_b = t[7:0];
        x8_sg = 1'($urandom_range(0, 1));
        x8_tag = 3'($urandom_range(0, 7));
        x8_iv = 1'b1;
    endtask

    task automatic new32();
        x32_a = pick(32);
        x32_b = pick(32);
        x32_sg = 1'($urandom_range(0, 1));
        x32_tag = 4'($urandom_range(0, 15));
        x32_iv = 1'b1;
    endtask

    task automatic test_sweep();
        logic [18:0] q8[$];
        logic [67:0] q32[$];
        logic [63:0] r;
        logic [18:0] e8;
        logic [67:0] e32;
        logic acc8, acc32;
        int n_items = 5000;
        new8();
        new32();
        x8_or = 1'b1;
        x32_or = 1'b1;
        for (int i = 0; i < n_items + 20; i++) begin
            @(negedge clk);
            if (x8_ov && x8_or) begin
                n_chk++;
                if (q8.size() == 0) begin n_fail++; $display("FAIL sw8_extra: got %h with nothing expected", {x8_otag, x8_prod}); end
                else begin
                    e8 = q8.pop_front();
                    if ({x8_otag, x8_prod} !== e8) begin n_fail++; $display("FAIL sw8_result: got %h want %h", {x8_otag, x8_prod}, e8); end
                end
            end
            if (x32_ov && x32_or) begin
                n_chk++;
                if (q32.size() == 0) begin n_fail++; $display("FAIL sw32_extra: got %h with nothing expected", {x32_otag, x32_prod}); end
                else begin
                    e32 = q32.pop_front();
                    if ({x32_otag, x32_prod} !== e32) begin n_fail++; $display("FAIL sw32_result: got %h want %h", {x32_otag, x32_prod}, e32); end
                end
            end
            acc8 = x8_iv && x8_ir;
            acc32 = x32_iv && x32_ir;
            if (acc8) begin
                r = ref_mul({56'd0, x8_a}, {56'd0, x8_b}, x8_sg, 8);
                q8.push_back({x8_tag, r[15:0]});
            end
            if (acc32) begin
                r = ref_mul({32'd0, x32_a}, {32'd0, x32_b}, x32_sg, 32);
                q32.push_back({x32_tag, r});
            end
            @(posedge clk);
            #1;
            if (acc8) begin
                if (i < n_items) new8(); else x8_iv = 1'b0;
            end
            if (acc32) begin
                if (i < n_items) new32(); else x32_iv = 1'b0;
            end
            x8_or = (i < n_items) ? ($urandom_range(0, 3) != 0) : 1'b1;
            x32_or = (i < n_items) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        n_chk++; if (q8.size() != 0 || x8_iv) begin n_fail++; $display("FAIL sw8_leftover: %0d results missing", q8.size()); end
        n_chk++; if (q32.size() != 0 || x32_iv) begin n_fail++; $display("FAIL sw32_leftover: %0d results missing", q32.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_signed = 1'b0; a = 16'd0; b = 16'd0; in_tag = 4'd0; out_ready = 1'b0;
        x8_iv = 1'b0; x8_sg = 1'b0; x8_a = 8'd0; x8_b = 8'd0; x8_tag = 3'd0; x8_or = 1'b0;
        x32_iv = 1'b0; x32_sg = 1'b0; x32_a = 32'd0; x32_b = 32'd0; x32_tag = 4'd0; x32_or = 1'b0;
        first_acc_cyc = -1; first_ov_cyc = -1; last_acc_cyc = 0;
        last_acc = 1'b0; last_del = 1'b0;
        test_reset();
        test_signed_corners();
        test_unsigned_corners();
        test_throughput();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
